dsp_integrator: RTL

Running-sum block, the inverse of the team's first-difference stage: y[n] = y[n-1] + x[n].
Used at the reconstruction end of the DSP chain. Feeding a differentiated stream through it in wrap mode recovers the original samples.
Also supports integrate-and-dump operation, a block average without the divide, for decimating paths.

---
 rtl/dsp_integrator_pkg.sv | 21 ++
 rtl/sat_adder.sv | 30 +++
 rtl/dsp_integrator.sv | 90 +++++++++
 3 files changed

// File: rtl/dsp_integrator_pkg.sv
// Shared constants and helpers for the running-sum integrator.
// Provides mode encodings, signed range limits and sign extension.
package dsp_integrator_pkg;

  localparam logic MODE_CONT = 1'b0;
  localparam logic MODE_DUMP = 1'b1;

  // Signed limit of a width-bit two's complement value; callers take the low width bits.
  function automatic logic [63:0] signed_limit(input int width, input logic want_max);
    logic [63:0] msb;
    msb = 64'd1 << (width - 1);
    return want_max ? (msb - 64'd1) : (~msb + 64'd1);
  endfunction

  function automatic logic [63:0] sign_extend(input logic [63:0] value, input int width);
    logic [63:0] shifted;
    shifted = value << (64 - width);
    return $unsigned($signed(shifted) >>> (64 - width));
  endfunction

endpackage

// File: rtl/sat_adder.sv
// Combinational two's complement adder with overflow detect and optional clamping.
// With saturate=0 the wrapped sum passes through unchanged.
module sat_adder
  import dsp_integrator_pkg::*;
#(
  parameter int width    = 16,
  parameter bit saturate = 1'b1
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic [width-1:0] sum,
  output logic             ovf
);

  localparam logic [width-1:0] max_val = width'(signed_limit(width, 1'b1));
  localparam logic [width-1:0] min_val = width'(signed_limit(width, 1'b0));

  logic [width-1:0] raw;

  // NOTE: every output gets a default before any condition so no latch is inferred.
  always_comb begin
    raw = a + b;
    ovf = (a[width-1] == b[width-1]) && (raw[width-1] != a[width-1]);
    sum = raw;
    if (saturate && ovf) begin
      sum = a[width-1] ? min_val : max_val;
    end
  end

endmodule

// File: rtl/dsp_integrator.sv
// Running-sum integrator y[n] = y[n-1] + x[n], with continuous and integrate-and-dump modes.
// Holds the accumulator, dump counter, registered mode, output registers and sticky overflow.
module dsp_integrator
  import dsp_integrator_pkg::*;
#(
  parameter int word_size = 8,
  parameter int acc_size  = 16,
  parameter int dump_len  = 8,
  parameter int saturate  = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear,
  input  logic                hold,
  input  logic                mode,
  input  logic                valid_in,
  input  logic [word_size-1:0] Data_in,
  output logic [acc_size-1:0] Data_out,
  output logic                valid_out,
  output logic                overflow
);

  localparam int              cnt_w    = $clog2(dump_len);
  localparam logic [cnt_w-1:0] last_cnt = cnt_w'(dump_len - 1);

  logic [acc_size-1:0] acc, base, sample, sum;
  logic [cnt_w-1:0]    count, count_eff;
  logic                mode_q, mode_change, ovf;

  // A mode change restarts the sum, so the same-cycle sample sees a zero base and count.
  always_comb begin
    mode_change = (mode != mode_q);
    base        = mode_change ? '0 : acc;
    count_eff   = mode_change ? '0 : count;
    sample      = acc_size'(sign_extend(64'(Data_in), word_size));
  end

  sat_adder #(
    .width   (acc_size),
    .saturate(saturate != 0)
  ) u_sat_adder (
    .a  (base),
    .b  (sample),
    .sum(sum),
    .ovf(ovf)
  );

  // NOTE: state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      count     <= '0;
      mode_q    <= MODE_CONT;
      Data_out  <= '0;
      valid_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (clear) begin
        acc      <= '0;
        count    <= '0;
        Data_out <= '0;
        overflow <= 1'b0;
      end else if (!hold) begin
        if (mode_change) begin
          mode_q <= mode;
          acc    <= '0;
          count  <= '0;
        end
        if (valid_in) begin
          overflow <= overflow | ovf;
          if (mode == MODE_CONT) begin
            acc       <= sum;
            Data_out  <= sum;
            valid_out <= 1'b1;
          end else if (count_eff == last_cnt) begin
            Data_out  <= sum;
            valid_out <= 1'b1;
            acc       <= '0;
            count     <= '0;
          end else begin
            acc   <= sum;
            count <= count_eff + 1'b1;
          end
        end
      end
    end
  end

endmodule
